um_user_module: RTL and testbench
=================================

# um_user_module

User module (`um`) sitting between the platform's packet input/output interfaces and the DMA, match-engine and local-bus infrastructure. The packet path is a store-and-forward buffer: 134-bit words are accepted, whole packets are committed or discarded on their tail word, and committed packets are replayed to the output under downstream backpressure. The DMA and match ports are idle tie-offs. A local-bus register slave exposes status, packet counters and a free-running timer.

## Interface
- `DATA_DEPTH`, 512: words in the packet data FIFO (power of 2).
- `VALID_DEPTH`, 64: entries in the packet-status FIFO.
- `RDY_THRESH`, 384: data-FIFO occupancy above which `pktout_ready` drops.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pktin_data` in 134, `pktin_data_wr` in 1: input word and its strobe. Bits [133:132]: 01 = head, 11 = middle, 10 = tail.
- `pktin_data_valid` in 1, `pktin_data_valid_wr` in 1: packet status, strobed with the tail word. Valid = 1 keeps the packet.
- `pktin_ready` in 1: downstream can accept `pktout_*`.
- `pktout_data` out 134, `pktout_data_wr` out 1, `pktout_data_valid` out 1, `pktout_data_valid_wr` out 1: output packet stream.
- `pktout_ready` out 1: `um` can accept input.
- `um_timestamp` in 64: platform time, readable over the local bus.
- `um_timer` out 64: free-running cycle counter.
- `dma2um_data` in 134, `dma2um_data_wr` in 1, `dma2um_ready` in 1: ignored.
- `um2dma_ready` out 1: constant 1.
- `um2dma_data` out 134, `um2dma_data_wr` out 1: constant 0.
- `um2me_key_wr` out 1, `um2me_key_valid` out 1, `um2match_key` out 512: constant 0.
- `um2me_ready` in 1, `me2um_id_wr` in 1, `match2um_id` in 16: ignored.
- `um2match_gme_alful` out 1: constant 0.
- `ctrl_valid` in 1, `ctrl2um_cs_n` in 1, `ctrl_cmd` in 1 (1 = read, 0 = write), `ctrl_addr` in 32, `ctrl_datain` in 32: local-bus request.
- `ctrl_dataout` out 32, `um2ctrl_ack_n` out 1: local-bus response.

## Operation
**Ingress**
- On every `pktin_data_wr`, the word is written at the write pointer.
- On a head word, the pointer position is latched as the packet start.
- On a tail word, with `pktin_data_valid_wr` = 1:
  - if `pktin_data_valid` = 1, the packet is committed: the write pointer advances and the packet word count is pushed to the status FIFO;
  - if `pktin_data_valid` = 0, the packet is dropped: the write pointer rewinds to the latched start.
- A word arriving while the data FIFO is full sets a sticky overflow flag. That word and the rest of its packet are discarded, and the packet counts as dropped.
- A head word that arrives mid-packet restarts the packet at the new head. The partial packet is discarded and counts as dropped.
- Idle cycles (`pktin_data_wr` = 0) inside a packet are legal.

**Egress FSM** (states IDLE, SEND)
- IDLE → SEND when the status FIFO is non-empty and `pktin_ready` = 1. The entry is popped and its word count loaded.
- In SEND, one word is output per cycle while `pktin_ready` = 1. The output pauses (strobe low) while `pktin_ready` = 0.
- On the last word, `pktout_data_valid` and `pktout_data_valid_wr` = 1. The FSM returns to IDLE, or goes directly to the next packet.

**Local bus**
- A request is `ctrl_valid` = 1 with `ctrl2um_cs_n` = 0.
- `um2ctrl_ack_n` pulses low for one cycle, one cycle after the request.
- Registers:
  - 0x0: status. Bit 0 = overflow (write 1 to clear); bit 1 = `pktout_ready`.
  - 0x4: packets in (committed).
  - 0x8: packets out.
  - 0xC: packets dropped.
  - 0x10 / 0x14: `um_timestamp` low / high words.
  - 0x18 / 0x1C: `um_timer` low / high words.
- Unmapped reads return 0.

## Timing
- All outputs are registered. Every output is 0 in reset except `um2dma_ready` = 1 and `pktout_ready` = 1.
- Latency, tail accepted → first output word: 2 cycles when `pktin_ready` = 1.
- `pktout_ready` = (occupancy ≤ `RDY_THRESH`). Upstream may still send up to 8 more words after it drops.
- Status FIFO full: `pktout_ready` = 0.
- Simultaneous commit and pop are both performed in the same cycle.
- Counters are 32-bit and wrap.
- Asserting reset mid-packet discards all buffered data and returns the FSM to IDLE.

## Configuration
- `UM_PKT_CNT_EN` defined: the counter registers 0x4, 0x8 and 0xC are implemented.
- `UM_PKT_CNT_EN` not defined: those registers read 0 and the counter logic is absent. The packet path is unchanged.

## Test plan
- Reset, then send head {01,0xff}, an idle cycle, then middle words {11,0xff}, {11, 0,48'h1,68'b0,4'hf,8'b0}, {11,0x2}, {11,0x3}, then tail {10,0x4} with valid = 1 → the 6 words appear unchanged, starting 2 cycles after the tail. `pktout_data_valid_wr`/`pktout_data_valid` = 1 only on the 10 word. Reg 0x4 = 1 and reg 0x8 = 1.
- The same packet with tail valid = 0 → no output, reg 0xC = 1, and FIFO occupancy back to 0.
- Hold `pktin_ready` = 0 and send 3 packets, then release it → 3 packets out back-to-back, in order, none lost.
- Send packets until occupancy exceeds 384 → `pktout_ready` = 0; drain the output → `pktout_ready` returns to 1.
- Overflow the data FIFO → status bit 0 = 1 and the offending packet is dropped; writing 1 to 0x0 clears the bit.
- Local-bus read of 0x18 on two consecutive requests → `ctrl_dataout` increases; each ack is low for exactly 1 cycle.

Source files
------------

// File: rtl/um_user_module.sv
// um_user_module: store-and-forward packet buffer, egress replay FSM, local-bus status/counter registers.
// Optional packet counters (0x4/0x8/0xC) are built only when UM_PKT_CNT_EN is defined.
module um_user_module #(
  parameter int DATA_DEPTH  = 512,
  parameter int VALID_DEPTH = 64,
  parameter int RDY_THRESH  = 384
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] pktin_data,
  input  logic         pktin_data_wr,
  input  logic         pktin_data_valid,
  input  logic         pktin_data_valid_wr,
  input  logic         pktin_ready,
  output logic [133:0] pktout_data,
  output logic         pktout_data_wr,
  output logic         pktout_data_valid,
  output logic         pktout_data_valid_wr,
  output logic         pktout_ready,
  input  logic [63:0]  um_timestamp,
  output logic [63:0]  um_timer,
  input  logic [133:0] dma2um_data,
  input  logic         dma2um_data_wr,
  input  logic         dma2um_ready,
  output logic         um2dma_ready,
  output logic [133:0] um2dma_data,
  output logic         um2dma_data_wr,
  output logic         um2me_key_wr,
  output logic         um2me_key_valid,
  output logic [511:0] um2match_key,
  input  logic         um2me_ready,
  input  logic         me2um_id_wr,
  input  logic [15:0]  match2um_id,
  output logic         um2match_gme_alful,
  input  logic         ctrl_valid,
  input  logic         ctrl2um_cs_n,
  input  logic         ctrl_cmd,
  input  logic [31:0]  ctrl_addr,
  input  logic [31:0]  ctrl_datain,
  output logic [31:0]  ctrl_dataout,
  output logic         um2ctrl_ack_n
);
  localparam int AW  = $clog2(DATA_DEPTH);
  localparam int PW  = AW + 1;
  localparam int SW  = $clog2(VALID_DEPTH);
  localparam int SPW = SW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [133:0]   mem [DATA_DEPTH];
  logic [PW-1:0]  cnt_mem [VALID_DEPTH];
  logic [PW-1:0]  wr_ptr_q, commit_ptr_q, rd_ptr_q, cnt_q, cnt_d, wa, occ;
  logic [SPW-1:0] st_wr_q, st_rd_q;
  logic           active_q, ovf_q;
  logic           is_head, is_tail, full, st_full, st_empty, ovf_evt, accept, commit, ovf_clr;
  state_t         state_q, state_d;
  logic           pop, rd_en, last;
  logic [133:0]   pktout_data_q;
  logic           pktout_wr_q, pktout_vld_q, pktout_vld_wr_q, pktout_ready_q;
  logic           ctrl_req, ack_n_q;
  logic [31:0]    dout_q, rd_val;
  logic [63:0]    timer_q;

  assign is_head  = pktin_data_wr && (pktin_data[133:132] == 2'b01);
  assign is_tail  = pktin_data_wr && (pktin_data[133:132] == 2'b10);
  // A head always (re)starts at the committed pointer, discarding any partial packet.
  assign wa       = is_head ? commit_ptr_q : wr_ptr_q;
  assign full     = (wa - rd_ptr_q) == PW'(DATA_DEPTH);
  assign st_full  = (st_wr_q - st_rd_q) == SPW'(VALID_DEPTH);
  assign st_empty = (st_wr_q == st_rd_q);
  assign ovf_evt  = pktin_data_wr && (is_head || active_q) && full;
  assign accept   = pktin_data_wr && (is_head || active_q) && !full;
  assign commit   = accept && is_tail && pktin_data_valid_wr && pktin_data_valid && !st_full;
  assign occ      = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk) begin
    if (accept) mem[wa[AW-1:0]] <= pktin_data;
    if (commit) cnt_mem[st_wr_q[SW-1:0]] <= wa + PW'(1) - commit_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      st_wr_q      <= '0;
      active_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (ovf_evt) begin
        wr_ptr_q <= commit_ptr_q;
        active_q <= 1'b0;
      end else if (accept) begin
        if (!is_tail) begin
          wr_ptr_q <= wa + PW'(1);
          active_q <= 1'b1;
        end else begin
          active_q <= 1'b0;
          if (commit) begin
            wr_ptr_q     <= wa + PW'(1);
            commit_ptr_q <= wa + PW'(1);
            st_wr_q      <= st_wr_q + SPW'(1);
          end else begin
            wr_ptr_q <= commit_ptr_q;
          end
        end
      end
      if (ovf_evt)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    rd_en   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (pktin_ready && !st_empty) begin
        pop     = 1'b1;
        cnt_d   = cnt_mem[st_rd_q[SW-1:0]];
        state_d = SEND;
      end
      SEND: if (pktin_ready) begin
        rd_en = 1'b1;
        cnt_d = cnt_q - PW'(1);
        if (cnt_q == PW'(1)) begin
          last = 1'b1;
          if (!st_empty) begin
            pop   = 1'b1;
            cnt_d = cnt_mem[st_rd_q[SW-1:0]];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      rd_ptr_q        <= '0;
      st_rd_q         <= '0;
      pktout_data_q   <= '0;
      pktout_wr_q     <= 1'b0;
      pktout_vld_q    <= 1'b0;
      pktout_vld_wr_q <= 1'b0;
      pktout_ready_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) st_rd_q <= st_rd_q + SPW'(1);
      if (rd_en) begin
        rd_ptr_q      <= rd_ptr_q + PW'(1);
        pktout_data_q <= mem[rd_ptr_q[AW-1:0]];
      end
      pktout_wr_q     <= rd_en;
      pktout_vld_q    <= last;
      pktout_vld_wr_q <= last;
      pktout_ready_q  <= (occ <= PW'(RDY_THRESH)) && !st_full;
    end
  end

  assign ctrl_req = ctrl_valid && !ctrl2um_cs_n;
  assign ovf_clr  = ctrl_req && !ctrl_cmd && (ctrl_addr == 32'h0) && ctrl_datain[0];

`ifdef UM_PKT_CNT_EN
  logic [31:0] pkt_in_q, pkt_out_q, pkt_drop_q;
  logic [1:0]  drop_inc;
  // A head arriving mid-packet while full drops both the partial and the new packet.
  assign drop_inc = 2'(ovf_evt) + 2'(is_head && active_q) + 2'(accept && is_tail && !commit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_in_q   <= '0;
      pkt_out_q  <= '0;
      pkt_drop_q <= '0;
    end else begin
      pkt_in_q   <= pkt_in_q + 32'(commit);
      pkt_out_q  <= pkt_out_q + 32'(last);
      pkt_drop_q <= pkt_drop_q + 32'(drop_inc);
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (ctrl_addr)
      32'h00:  rd_val = {30'b0, pktout_ready_q, ovf_q};
`ifdef UM_PKT_CNT_EN
      32'h04:  rd_val = pkt_in_q;
      32'h08:  rd_val = pkt_out_q;
      32'h0C:  rd_val = pkt_drop_q;
`endif
      32'h10:  rd_val = um_timestamp[31:0];
      32'h14:  rd_val = um_timestamp[63:32];
      32'h18:  rd_val = timer_q[31:0];
      32'h1C:  rd_val = timer_q[63:32];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_n_q <= 1'b0;
      dout_q  <= '0;
      timer_q <= '0;
    end else begin
      ack_n_q <= !ctrl_req;
      if (ctrl_req && ctrl_cmd) dout_q <= rd_val;
      timer_q <= timer_q + 64'd1;
    end
  end

  logic unused_in;
  assign unused_in = ^{dma2um_data, dma2um_data_wr, dma2um_ready, um2me_ready, me2um_id_wr,
                       match2um_id, ctrl_datain[31:1]};

  assign pktout_data          = pktout_data_q;
  assign pktout_data_wr       = pktout_wr_q;
  assign pktout_data_valid    = pktout_vld_q;
  assign pktout_data_valid_wr = pktout_vld_wr_q;
  assign pktout_ready         = pktout_ready_q;
  assign um_timer             = timer_q;
  assign ctrl_dataout         = dout_q;
  assign um2ctrl_ack_n        = ack_n_q;
  assign um2dma_ready         = 1'b1;
  assign um2dma_data          = '0;
  assign um2dma_data_wr       = 1'b0;
  assign um2me_key_wr         = 1'b0;
  assign um2me_key_valid      = 1'b0;
  assign um2match_key         = '0;
  assign um2match_gme_alful   = 1'b0;
endmodule

// File: tb/tb_um_user_module.sv
// Directed bench for um_user_module: replay, drop, restart, backpressure, threshold, overflow,
// local-bus registers and reset mid-packet.
module tb_um_user_module;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [133:0] pktin_data = '0;
  logic         pktin_data_wr = 1'b0, pktin_data_valid = 1'b0, pktin_data_valid_wr = 1'b0;
  logic         pktin_ready = 1'b1;
  logic [133:0] pktout_data;
  logic         pktout_data_wr, pktout_data_valid, pktout_data_valid_wr, pktout_ready;
  logic [63:0]  um_timestamp = 64'h0123_4567_89ab_cdef;
  logic [63:0]  um_timer;
  logic [133:0] dma2um_data = '0;
  logic         dma2um_data_wr = 1'b0, dma2um_ready = 1'b0;
  logic         um2dma_ready, um2dma_data_wr, um2me_key_wr, um2me_key_valid, um2match_gme_alful;
  logic [133:0] um2dma_data;
  logic [511:0] um2match_key;
  logic         um2me_ready = 1'b0, me2um_id_wr = 1'b0;
  logic [15:0]  match2um_id = '0;
  logic         ctrl_valid = 1'b0, ctrl2um_cs_n = 1'b1, ctrl_cmd = 1'b0;
  logic [31:0]  ctrl_addr = '0, ctrl_datain = '0;
  logic [31:0]  ctrl_dataout;
  logic         um2ctrl_ack_n;

  always #5 clk = ~clk;

  um_user_module dut (
    .clk(clk), .rst_n(rst_n),
    .pktin_data(pktin_data), .pktin_data_wr(pktin_data_wr),
    .pktin_data_valid(pktin_data_valid), .pktin_data_valid_wr(pktin_data_valid_wr),
    .pktin_ready(pktin_ready),
    .pktout_data(pktout_data), .pktout_data_wr(pktout_data_wr),
    .pktout_data_valid(pktout_data_valid), .pktout_data_valid_wr(pktout_data_valid_wr),
    .pktout_ready(pktout_ready),
    .um_timestamp(um_timestamp), .um_timer(um_timer),
    .dma2um_data(dma2um_data), .dma2um_data_wr(dma2um_data_wr), .dma2um_ready(dma2um_ready),
    .um2dma_ready(um2dma_ready), .um2dma_data(um2dma_data), .um2dma_data_wr(um2dma_data_wr),
    .um2me_key_wr(um2me_key_wr), .um2me_key_valid(um2me_key_valid), .um2match_key(um2match_key),
    .um2me_ready(um2me_ready), .me2um_id_wr(me2um_id_wr), .match2um_id(match2um_id),
    .um2match_gme_alful(um2match_gme_alful),
    .ctrl_valid(ctrl_valid), .ctrl2um_cs_n(ctrl2um_cs_n), .ctrl_cmd(ctrl_cmd),
    .ctrl_addr(ctrl_addr), .ctrl_datain(ctrl_datain),
    .ctrl_dataout(ctrl_dataout), .um2ctrl_ack_n(um2ctrl_ack_n)
  );

`ifdef UM_PKT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned tail_cyc = 0;
  int unsigned rel_cyc = 0;
  logic [133:0] oq[$];
  logic [1:0]   ov[$];
  int unsigned  oc[$];
  logic [133:0] eq[$];
  logic [1:0]   ev[$];
  logic [133:0] w1 [6];
  logic [31:0]  rd, rd2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && pktout_data_wr) begin
      oq.push_back(pktout_data);
      ov.push_back({pktout_data_valid, pktout_data_valid_wr});
      oc.push_back(cyc);
    end

  function automatic logic [31:0] cexp(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [133:0] d, input logic lst, input logic keep);
    @(negedge clk);
    pktin_data = d; pktin_data_wr = 1'b1;
    pktin_data_valid_wr = lst; pktin_data_valid = lst & keep;
  endtask

  task automatic idle();
    @(negedge clk);
    pktin_data_wr = 1'b0; pktin_data_valid_wr = 1'b0; pktin_data_valid = 1'b0;
  endtask

  task automatic pkt(input int id, input int len, input logic keep, input logic show);
    logic [1:0]   t;
    logic [131:0] pl;
    for (int i = 0; i < len; i++) begin
      t  = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
      pl = {100'(id), 32'(i)};
      put({t, pl}, i == len - 1, keep);
      if (show) begin
        eq.push_back({t, pl});
        ev.push_back((i == len - 1) ? 2'b11 : 2'b00);
      end
    end
    idle();
    tail_cyc = cyc;
  endtask

  task automatic send_w1(input logic keep);
    for (int i = 0; i < 6; i++) begin
      put(w1[i], i == 5, keep);
      if (i == 0) idle();
      if (keep) begin
        eq.push_back(w1[i]);
        ev.push_back((i == 5) ? 2'b11 : 2'b00);
      end
    end
    idle();
    tail_cyc = cyc;
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int k = 0; k < budget && oq.size() < n; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_cnt"}, 134'(oq.size()), 134'(eq.size()));
    for (int i = 0; i < eq.size() && i < oq.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), oq[i], eq[i]);
      chk($sformatf("%s_v%0d", tag, i), 134'(ov[i]), 134'(ev[i]));
    end
    oq.delete(); ov.delete(); oc.delete(); eq.delete(); ev.delete();
  endtask

  task automatic lb_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ctrl_valid = 1'b1; ctrl2um_cs_n = 1'b0; ctrl_cmd = 1'b1; ctrl_addr = a;
    @(negedge clk);
    ctrl_valid = 1'b0; ctrl2um_cs_n = 1'b1;
    d = ctrl_dataout;
    chk("ack_lo", 134'(um2ctrl_ack_n), 134'(0));
    @(negedge clk);
    chk("ack_hi", 134'(um2ctrl_ack_n), 134'(1));
  endtask

  task automatic lb_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ctrl_valid = 1'b1; ctrl2um_cs_n = 1'b0; ctrl_cmd = 1'b0; ctrl_addr = a; ctrl_datain = d;
    @(negedge clk);
    ctrl_valid = 1'b0; ctrl2um_cs_n = 1'b1;
    chk("wack_lo", 134'(um2ctrl_ack_n), 134'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    w1[0] = {2'b01, 132'hff};
    w1[1] = {2'b11, 132'hff};
    w1[2] = {2'b11, 4'h0, 48'h1, 68'b0, 4'hf, 8'b0};
    w1[3] = {2'b11, 132'h2};
    w1[4] = {2'b11, 132'h3};
    w1[5] = {2'b10, 132'h4};

    repeat (3) @(negedge clk);
    chk("rst_pktout_ready", 134'(pktout_ready), 134'(1));
    chk("rst_dma_ready", 134'(um2dma_ready), 134'(1));
    chk("rst_out_wr", 134'(pktout_data_wr), 134'(0));
    chk("rst_out_vld", 134'(pktout_data_valid), 134'(0));
    chk("rst_out_data", pktout_data, 134'(0));
    chk("rst_ack_n", 134'(um2ctrl_ack_n), 134'(0));
    chk("rst_dout", 134'(ctrl_dataout), 134'(0));
    chk("rst_timer", 134'(um_timer), 134'(0));
    rst_n = 1'b1;
    rel_cyc = cyc;
    repeat (2) @(negedge clk);

    // single packet replay with idle cycle after head
    send_w1(1'b1);
    wait_out(6, 40);
    chk("p1_latency", 134'((oc.size() > 0) ? oc[0] - tail_cyc : 999), 134'(2));
    compare_out("p1");
    lb_rd(32'h4, rd); chk("reg_in_1", 134'(rd), 134'(cexp(1)));
    lb_rd(32'h8, rd); chk("reg_out_1", 134'(rd), 134'(cexp(1)));

    // same packet discarded on its tail
    send_w1(1'b0);
    wait_out(1, 10);
    compare_out("p2");
    lb_rd(32'hC, rd); chk("reg_drop_1", 134'(rd), 134'(cexp(1)));

    // head mid-packet restarts: only the second packet comes out
    put({2'b01, 100'd20, 32'd0}, 1'b0, 1'b0);
    put({2'b11, 100'd20, 32'd1}, 1'b0, 1'b0);
    pkt(21, 4, 1'b1, 1'b1);
    wait_out(4, 40);
    compare_out("restart");
    lb_rd(32'hC, rd); chk("reg_drop_2", 134'(rd), 134'(cexp(2)));

    // backpressure: three packets held then released back-to-back
    pktin_ready = 1'b0;
    pkt(30, 2, 1'b1, 1'b1);
    pkt(31, 4, 1'b1, 1'b1);
    pkt(32, 3, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("hold_none", 134'(oq.size()), 134'(0));
    pktin_ready = 1'b1;
    wait_out(9, 60);
    chk("b2b_span", 134'((oc.size() == 9) ? oc[8] - oc[0] : 999), 134'(8));
    compare_out("b2b");

    // fill past the ready threshold, then overflow the data FIFO
    pktin_ready = 1'b0;
    for (int p = 0; p < 7; p++) pkt(40 + p, 50, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("rdy_at_350", 134'(pktout_ready), 134'(1));
    pkt(47, 50, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("rdy_at_400", 134'(pktout_ready), 134'(0));
    pkt(48, 50, 1'b1, 1'b1);
    pkt(49, 50, 1'b1, 1'b1);
    pkt(50, 20, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    lb_rd(32'h0, rd); chk("stat_ovf", 134'(rd), 134'(1));
    lb_rd(32'hC, rd); chk("reg_drop_3", 134'(rd), 134'(cexp(3)));
    pktin_ready = 1'b1;
    wait_out(500, 800);
    compare_out("drain");
    repeat (4) @(negedge clk);
    chk("rdy_drained", 134'(pktout_ready), 134'(1));
    lb_rd(32'h0, rd); chk("stat_ovf_rdy", 134'(rd), 134'(3));
    lb_wr(32'h0, 32'h1);
    lb_rd(32'h0, rd); chk("stat_cleared", 134'(rd), 134'(2));
    pkt(60, 5, 1'b1, 1'b1);
    wait_out(5, 40);
    compare_out("recover");
    lb_rd(32'h4, rd); chk("reg_in_16", 134'(rd), 134'(cexp(16)));
    lb_rd(32'h8, rd); chk("reg_out_16", 134'(rd), 134'(cexp(16)));

    // timestamp, timer and unmapped reads
    lb_rd(32'h10, rd); chk("ts_lo", 134'(rd), 134'(32'h89ab_cdef));
    lb_rd(32'h14, rd); chk("ts_hi", 134'(rd), 134'(32'h0123_4567));
    lb_rd(32'h18, rd);
    lb_rd(32'h18, rd2);
    chk("timer_step", 134'(rd2 - rd), 134'(3));
    lb_rd(32'h1C, rd); chk("timer_hi", 134'(rd), 134'(0));
    lb_rd(32'h24, rd); chk("unmapped", 134'(rd), 134'(0));
    chk("timer_out", 134'(um_timer), 134'(cyc - rel_cyc));

    // reset in the middle of a packet
    put({2'b01, 100'd70, 32'd0}, 1'b0, 1'b0);
    put({2'b11, 100'd70, 32'd1}, 1'b0, 1'b0);
    @(negedge clk);
    pktin_data_wr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pkt(71, 3, 1'b1, 1'b1);
    wait_out(3, 40);
    compare_out("post_rst");
    lb_rd(32'h0, rd); chk("stat_post_rst", 134'(rd), 134'(2));
    lb_rd(32'h4, rd); chk("reg_in_post_rst", 134'(rd), 134'(cexp(1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
